// File: rtl/vga_pkg.sv
// Shared constants, FSM state type and CRC-32 helper for the VGA pixel-path checkers.
package vga_pkg;

    localparam logic [31:0] CrcPoly   = 32'h04C11DB7;
    localparam logic [31:0] CrcInit   = 32'hFFFFFFFF;
    localparam logic [31:0] CrcXorOut = 32'hFFFFFFFF;

    localparam int unsigned DefHActive = 640;
    localparam int unsigned DefVActive = 480;
    localparam int unsigned DefCoordW  = 10;
    localparam int unsigned DefColorW  = 8;

    typedef enum logic [1:0] {
        StIdle,
        StSkip,
        StCapture,
        StDone
    } sig_state_e;

    // One MSB-first, non-reflected CRC-32 bit step.
    function automatic logic [31:0] crc32_step(input logic [31:0] crc, input logic din);
        return {crc[30:0], 1'b0} ^ ((crc[31] ^ din) ? CrcPoly : 32'h0);
    endfunction

endpackage

// File: rtl/crc32_parallel.sv
// Combinational next-state CRC-32 over a DW-bit data word, MSB of data consumed first.
module crc32_parallel
    import vga_pkg::*;
#(
    parameter int unsigned DW = 24
) (
    input  logic [31:0]   crc_in,
    input  logic [DW-1:0] data,
    output logic [31:0]   crc_out
);

    logic [31:0]   crc_acc;
    logic [DW-1:0] data_sh;

    always_comb begin
        crc_acc = crc_in;
        data_sh = data;
        for (int i = 0; i < int'(DW); i++) begin
            crc_acc = crc32_step(crc_acc, data_sh[DW-1]);
            data_sh = data_sh << 1;
        end
        crc_out = crc_acc;
    end

endmodule

// File: rtl/vga_frame_signature.sv
// Frame-signature monitor: skips N frames, then CRC-32s one visible frame and checks raster order.
// Optional feature macro: VGA_SIG_COMPARE_EN adds expected_sig / sig_match.
module vga_frame_signature
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DefHActive,
    parameter int unsigned V_ACTIVE = DefVActive,
    parameter int unsigned COORD_W  = DefCoordW,
    parameter int unsigned COLOR_W  = DefColorW
) (
    input  logic                   CLOCK_50,
    input  logic                   reset_key,
    input  logic                   start,
    input  logic [3:0]             skip_frames,
    input  logic                   pixel_valid,
    input  logic [COORD_W-1:0]     pixel_x,
    input  logic [COORD_W-1:0]     pixel_y,
    input  logic [COLOR_W-1:0]     vga_r,
    input  logic [COLOR_W-1:0]     vga_g,
    input  logic [COLOR_W-1:0]     vga_b,
`ifdef VGA_SIG_COMPARE_EN
    input  logic [31:0]            expected_sig,
    output logic                   sig_match,
`endif
    output logic                   busy,
    output logic                   sig_valid,
    output logic [31:0]            signature,
    output logic [2*COORD_W-1:0]   pixel_count,
    output logic                   order_err,
    output logic                   count_err
);

    localparam int unsigned CntW = 2 * COORD_W;
    localparam int unsigned DataW = 3 * COLOR_W;
    localparam logic [COORD_W-1:0] XLast = COORD_W'(H_ACTIVE - 1);
    localparam logic [COORD_W-1:0] YLast = COORD_W'(V_ACTIVE - 1);
    localparam logic [CntW-1:0] FrameSize = CntW'(H_ACTIVE * V_ACTIVE);

    sig_state_e          state_q, state_d;
    logic [3:0]          skip_cnt_q, skip_cnt_d;
    logic [31:0]         crc_q, crc_d;
    logic [31:0]         sig_q, sig_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                order_err_q, order_err_d;
    logic                count_err_q, count_err_d;
    logic [COORD_W-1:0]  prev_x_q, prev_x_d;
    logic [COORD_W-1:0]  prev_y_q, prev_y_d;

    logic                accepted, sof, eof, in_order, fold;
    logic [DataW-1:0]    pix_data;
    logic [31:0]         crc_seed, crc_next;

    assign accepted = pixel_valid && (pixel_x <= XLast) && (pixel_y <= YLast);
    assign sof      = accepted && (pixel_x == '0) && (pixel_y == '0);
    assign eof      = accepted && (pixel_x == XLast) && (pixel_y == YLast);
    assign pix_data = {vga_r, vga_g, vga_b};

    // Folding only ever starts over on a SOF, so the seed depends on the input alone.
    assign crc_seed = sof ? CrcInit : crc_q;

    always_comb begin
        if (prev_x_q == XLast) begin
            in_order = (pixel_x == '0) && (pixel_y == prev_y_q + COORD_W'(1));
        end else begin
            in_order = (pixel_x == prev_x_q + COORD_W'(1)) && (pixel_y == prev_y_q);
        end
    end

    crc32_parallel #(
        .DW (DataW)
    ) u_crc (
        .crc_in  (crc_seed),
        .data    (pix_data),
        .crc_out (crc_next)
    );

    always_comb begin
        state_d     = state_q;
        skip_cnt_d  = skip_cnt_q;
        crc_d       = crc_q;
        sig_d       = sig_q;
        cnt_d       = cnt_q;
        order_err_d = order_err_q;
        count_err_d = count_err_q;
        prev_x_d    = prev_x_q;
        prev_y_d    = prev_y_q;
        fold        = 1'b0;

        if (start) begin
            state_d     = StSkip;
            skip_cnt_d  = skip_frames;
            crc_d       = CrcInit;
            sig_d       = '0;
            cnt_d       = '0;
            order_err_d = 1'b0;
            count_err_d = 1'b0;
        end else begin
            unique case (state_q)
                StSkip: begin
                    if (sof) begin
                        if (skip_cnt_q == 4'd0) begin
                            state_d = StCapture;
                            fold    = 1'b1;
                        end else begin
                            skip_cnt_d = skip_cnt_q - 4'd1;
                        end
                    end
                end
                StCapture: begin
                    if (accepted) begin
                        fold = 1'b1;
                        if (sof) begin
                            // A new frame began before EOF: start over on this one.
                            order_err_d = 1'b1;
                            count_err_d = 1'b1;
                        end else if (!in_order) begin
                            order_err_d = 1'b1;
                        end
                    end
                end
                default: ;
            endcase

            if (fold) begin
                crc_d    = crc_next;
                prev_x_d = pixel_x;
                prev_y_d = pixel_y;
                if (sof) begin
                    cnt_d = CntW'(1);
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CntW'(1);
                end
                if (eof) begin
                    state_d = StDone;
                    sig_d   = crc_next ^ CrcXorOut;
                    if (cnt_d != FrameSize) begin
                        count_err_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset_key) begin
            state_q     <= StIdle;
            skip_cnt_q  <= '0;
            crc_q       <= CrcInit;
            sig_q       <= '0;
            cnt_q       <= '0;
            order_err_q <= 1'b0;
            count_err_q <= 1'b0;
            prev_x_q    <= '0;
            prev_y_q    <= '0;
        end else begin
            state_q     <= state_d;
            skip_cnt_q  <= skip_cnt_d;
            crc_q       <= crc_d;
            sig_q       <= sig_d;
            cnt_q       <= cnt_d;
            order_err_q <= order_err_d;
            count_err_q <= count_err_d;
            prev_x_q    <= prev_x_d;
            prev_y_q    <= prev_y_d;
        end
    end

`ifdef VGA_SIG_COMPARE_EN
    logic sig_match_q, sig_match_d;

    // Tracks the next-state so the match flag lines up with sig_valid.
    assign sig_match_d = (state_d == StDone) && (sig_d == expected_sig);

    always_ff @(posedge CLOCK_50) begin
        if (!reset_key) begin
            sig_match_q <= 1'b0;
        end else begin
            sig_match_q <= sig_match_d;
        end
    end

    assign sig_match = sig_match_q;
`endif

    assign busy        = (state_q == StSkip) || (state_q == StCapture);
    assign sig_valid   = (state_q == StDone);
    assign signature   = sig_q;
    assign pixel_count = cnt_q;
    assign order_err   = order_err_q;
    assign count_err   = count_err_q;

endmodule

// File: tb/tb_vga_frame_signature.sv
// Scoreboard bench for vga_frame_signature on a 4x2 raster; honours VGA_SIG_COMPARE_EN.
module tb_vga_frame_signature;

    localparam int unsigned H  = 4;
    localparam int unsigned V  = 2;
    localparam int unsigned CW = 10;
    localparam int unsigned KW = 8;

    typedef struct {
        int          x;
        int          y;
        logic [23:0] rgb;
    } pix_t;

    typedef struct {
        string       name;
        logic [31:0] sig;
        logic [19:0] cnt;
        logic        oerr;
        logic        cerr;
        logic        match;
    } exp_t;

    logic          CLOCK_50 = 1'b0;
    logic          reset_key;
    logic          start;
    logic [3:0]    skip_frames;
    logic          pixel_valid;
    logic [CW-1:0] pixel_x, pixel_y;
    logic [KW-1:0] vga_r, vga_g, vga_b;
    logic          busy, sig_valid, order_err, count_err;
    logic [31:0]   signature;
    logic [19:0]   pixel_count;
`ifdef VGA_SIG_COMPARE_EN
    logic [31:0]   expected_sig = 32'h0;
    logic          sig_match;
`endif

    always #5 CLOCK_50 = ~CLOCK_50;

    vga_frame_signature #(
        .H_ACTIVE (H),
        .V_ACTIVE (V),
        .COORD_W  (CW),
        .COLOR_W  (KW)
    ) dut (
        .CLOCK_50     (CLOCK_50),
        .reset_key    (reset_key),
        .start        (start),
        .skip_frames  (skip_frames),
        .pixel_valid  (pixel_valid),
        .pixel_x      (pixel_x),
        .pixel_y      (pixel_y),
        .vga_r        (vga_r),
        .vga_g        (vga_g),
        .vga_b        (vga_b),
`ifdef VGA_SIG_COMPARE_EN
        .expected_sig (expected_sig),
        .sig_match    (sig_match),
`endif
        .busy         (busy),
        .sig_valid    (sig_valid),
        .signature    (signature),
        .pixel_count  (pixel_count),
        .order_err    (order_err),
        .count_err    (count_err)
    );

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    // Reference CRC, byte-wise over r, g, b of each pixel in list order.
    function automatic logic [31:0] crc_of(input pix_t list[$]);
        logic [31:0] c;
        logic [7:0]  b;
        c = 32'hFFFFFFFF;
        foreach (list[i]) begin
            for (int k = 2; k >= 0; k--) begin
                b = list[i].rgb[k*8 +: 8];
                c = c ^ {b, 24'h0};
                for (int j = 0; j < 8; j++) c = c[31] ? ((c << 1) ^ 32'h04C11DB7) : (c << 1);
            end
        end
        return c ^ 32'hFFFFFFFF;
    endfunction

    function automatic logic [23:0] pat(input int seed, input int x, input int y);
        return {8'(seed * 37 + x * 16 + y), 8'(x ^ (y << 4) ^ seed), 8'(8'hA5 ^ (x * y) ^ seed)};
    endfunction

    // seed < 0: solid colour given by -seed-1 repeated in all channels.
    task automatic build(input int seed, output pix_t f[$]);
        pix_t p;
        f = {};
        for (int y = 0; y < int'(V); y++) begin
            for (int x = 0; x < int'(H); x++) begin
                p.x = x;
                p.y = y;
                p.rgb = (seed < 0) ? {3{8'(-seed - 1)}} : pat(seed, x, y);
                f.push_back(p);
            end
        end
    endtask

    task automatic set_expected(input logic [31:0] v);
`ifdef VGA_SIG_COMPARE_EN
        expected_sig = v;
`endif
    endtask

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic send_pix(input int x, input int y, input logic [23:0] rgb);
        pixel_valid = 1'b1;
        pixel_x = CW'(x);
        pixel_y = CW'(y);
        {vga_r, vga_g, vga_b} = rgb;
        step();
        pixel_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        pixel_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic send_list(input pix_t f[$]);
        foreach (f[i]) send_pix(f[i].x, f[i].y, f[i].rgb);
    endtask

    task automatic do_start(input logic [3:0] skip);
        start = 1'b1;
        skip_frames = skip;
        step();
        start = 1'b0;
    endtask

    task automatic expect_result(input string name, input logic [31:0] sig, input int cnt,
                                 input logic oerr, input logic cerr, input logic match);
        exp_t e;
        e.name = name;
        e.sig = sig;
        e.cnt = 20'(cnt);
        e.oerr = oerr;
        e.cerr = cerr;
        e.match = match;
        exp_q.push_back(e);
    endtask

    // Monitor: every rising sig_valid consumes one expected result.
    initial begin : monitor
        logic prev_sv;
        exp_t e;
        prev_sv = 1'b0;
        forever begin
            @(negedge CLOCK_50);
            if (sig_valid === 1'b1 && !prev_sv) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_sig_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check({e.name, "_signature"}, signature, e.sig);
                    check({e.name, "_pixel_count"}, pixel_count, e.cnt);
                    check({e.name, "_order_err"}, order_err, e.oerr);
                    check({e.name, "_count_err"}, count_err, e.cerr);
`ifdef VGA_SIG_COMPARE_EN
                    check({e.name, "_sig_match"}, sig_match, e.match);
`endif
                end
            end
            prev_sv = (sig_valid === 1'b1);
        end
    end

    initial begin : stimulus
        pix_t fz[$], fw[$], fp[$], fd[$];
        logic [31:0] crc_zero, crc_p;

        reset_key = 1'b0;
        start = 1'b0;
        skip_frames = 4'd0;
        pixel_valid = 1'b0;
        pixel_x = '0;
        pixel_y = '0;
        {vga_r, vga_g, vga_b} = 24'h0;
        idle(3);
        reset_key = 1'b1;
        idle(1);
        check("reset_busy", busy, 0);
        check("reset_sig_valid", sig_valid, 0);
        check("reset_signature", signature, 0);
        check("reset_pixel_count", pixel_count, 0);
        check("reset_order_err", order_err, 0);
        check("reset_count_err", count_err, 0);
`ifdef VGA_SIG_COMPARE_EN
        check("reset_sig_match", sig_match, 0);
`endif

        // All-zero frame, no skip; latency and busy handshake checked inline.
        build(-1, fz);
        crc_zero = crc_of(fz);
        set_expected(crc_zero);
        do_start(4'd0);
        check("start_busy", busy, 1);
        expect_result("zero", crc_zero, 8, 0, 0, 1);
        foreach (fz[i]) begin
            send_pix(fz[i].x, fz[i].y, fz[i].rgb);
            if (i == 0) check("fold_latency_count", pixel_count, 1);
            if (i == 6) check("pre_eof_sig_valid", sig_valid, 0);
        end
        check("eof_sig_valid", sig_valid, 1);
        check("eof_busy", busy, 0);
        idle(2);
        check("done_hold_signature", signature, crc_zero);

        // Skip two white frames, capture the third (zero) frame.
        build(-256, fw);
        do_start(4'd2);
        check("restart_clears_sig_valid", sig_valid, 0);
        check("restart_clears_signature", signature, 0);
        expect_result("skip2", crc_zero, 8, 0, 0, 1);
        send_list(fw);
        idle(2);
        send_list(fw);
        idle(2);
        check("skip_busy", busy, 1);
        check("skip_no_fold", pixel_count, 0);
        send_list(fz);
        idle(2);

        // Pixel (2,1) missing.
        build(1, fp);
        fd = fp;
        fd.delete(6);
        set_expected(crc_of(fp));
        do_start(4'd0);
        expect_result("drop", crc_of(fd), 7, 1, 1, 0);
        send_list(fd);
        idle(2);

        // Half-rate pixel enable plus off-screen coordinates that must be ignored.
        build(2, fp);
        set_expected(crc_of(fp));
        do_start(4'd0);
        expect_result("halfrate", crc_of(fp), 8, 0, 0, 1);
        send_pix(0, 2, 24'h123456);
        idle(1);
        send_pix(5, 0, 24'h654321);
        idle(1);
        foreach (fp[i]) begin
            send_pix(fp[i].x, fp[i].y, fp[i].rgb);
            idle(1);
            if (fp[i].x == int'(H) - 1) begin
                send_pix(4, fp[i].y, 24'hDEAD00);
                idle(1);
                send_pix(7, 3, 24'h00BEEF);
                idle(1);
            end
        end
        idle(2);

        // Reset after three pixels, then a clean capture.
        build(3, fp);
        set_expected(crc_of(fp));
        do_start(4'd0);
        for (int i = 0; i < 3; i++) send_pix(fp[i].x, fp[i].y, fp[i].rgb);
        reset_key = 1'b0;
        step();
        reset_key = 1'b1;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_sig_valid", sig_valid, 0);
        check("rst_mid_pixel_count", pixel_count, 0);
        check("rst_mid_signature", signature, 0);
        check("rst_mid_order_err", order_err, 0);
        check("rst_mid_count_err", count_err, 0);
        idle(1);
        do_start(4'd0);
        expect_result("after_reset", crc_of(fp), 8, 0, 0, 1);
        send_list(fp);
        idle(2);

        // start mid-capture re-arms; the tail of the aborted frame must not finish it.
        build(4, fp);
        set_expected(crc_of(fp));
        do_start(4'd0);
        for (int i = 0; i < 3; i++) send_pix(fp[i].x, fp[i].y, fp[i].rgb);
        do_start(4'd0);
        check("abort_busy", busy, 1);
        check("abort_pixel_count", pixel_count, 0);
        for (int i = 3; i < 8; i++) send_pix(fp[i].x, fp[i].y, fp[i].rgb);
        check("abort_tail_sig_valid", sig_valid, 0);
        expect_result("rearm", crc_of(fp), 8, 0, 0, 1);
        send_list(fp);
        idle(2);

        // SOF inside a capture restarts it and flags both errors.
        build(5, fp);
        set_expected(crc_of(fp));
        do_start(4'd0);
        expect_result("early_sof", crc_of(fp), 8, 1, 1, 1);
        send_pix(fp[0].x, fp[0].y, fp[0].rgb);
        send_pix(fp[1].x, fp[1].y, fp[1].rgb);
        send_list(fp);
        idle(2);

        // Single blue LSB flip at (1,0) against the zero-frame reference.
        fd = fz;
        fd[1].rgb = 24'h000001;
        set_expected(crc_zero);
        do_start(4'd0);
        expect_result("lsb_flip", crc_of(fd), 8, 0, 0, 0);
        send_list(fd);
        idle(3);

        check("all_results_seen", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vga_frame_signature.md
# vga_frame_signature

Synthesizable frame-signature monitor for the VGA pixel path, sitting alongside `world` on the `pixel_x`/`pixel_y`/RGB bus. On request, it waits a programmable number of frames, then folds every visible pixel of one frame into a CRC-32. It also checks raster order and pixel count. This gives an on-chip, resolution- and colour-depth-independent replacement for dumping a full image to compare frames.

## Interface
- `H_ACTIVE`, default 640, visible pixels per line.
- `V_ACTIVE`, default 480, visible lines per frame.
- `COORD_W`, default 10, width of `pixel_x`/`pixel_y`.
- `COLOR_W`, default 8, bits per colour channel; the CRC data word is `3*COLOR_W` bits.
- `CLOCK_50`  in  1  system clock; all logic on the rising edge.
- `reset_key`  in  1  reset, synchronous, active-low.
- `start`  in  1  one-cycle request to arm a capture.
- `skip_frames`  in  4  whole frames to let pass before capturing; sampled on `start`.
- `pixel_valid`  in  1  pixel-clock enable; one pixel per asserted cycle.
- `pixel_x`, `pixel_y`  in  `COORD_W`  current raster coordinates.
- `vga_r`, `vga_g`, `vga_b`  in  `COLOR_W`  pixel colour.
- `busy`  out  1  armed or capturing.
- `sig_valid`  out  1  signature complete and stable.
- `signature`  out  32  final CRC-32.
- `pixel_count`  out  `COORD_W*2`  visible pixels folded in.
- `order_err`  out  1  out-of-raster-order pixel seen during capture.
- `count_err`  out  1  frame ended with `pixel_count != H_ACTIVE*V_ACTIVE`.

## Operation
- An accepted pixel requires `pixel_valid` with `pixel_x < H_ACTIVE` and `pixel_y < V_ACTIVE`. All other cycles are ignored.
- SOF is an accepted pixel at (0,0). EOF is an accepted pixel at (`H_ACTIVE-1`,`V_ACTIVE-1`).
- FSM states:
  - IDLE: `start` goes to SKIP, loads the skip counter from `skip_frames`, and clears all outputs.
  - SKIP: on each SOF, if the counter is 0, go to CAPTURE and fold that SOF pixel; otherwise decrement the counter.
  - CAPTURE: fold each accepted pixel. On EOF, fold the pixel and go to DONE.
  - DONE: `sig_valid`=1, outputs held. `start` goes to SKIP.
- `start` in any state, including mid-capture, aborts and re-arms as from IDLE. `start` has priority over a simultaneous SOF or EOF.
- CRC-32 parameters:
  - Polynomial 0x04C11DB7, init 0xFFFFFFFF.
  - Data word {r,g,b} fed MSB first, no reflection.
  - `signature` = CRC register XOR 0xFFFFFFFF, latched on EOF.
- Raster check: each accepted pixel after SOF must be the successor of the previous one. The successor is x+1 on the same line, or (0, y+1) after x=`H_ACTIVE-1`. Any violation sets `order_err`, which is sticky until `start` or reset. The pixel is still folded in.
- A SOF seen during CAPTURE, before EOF, does the following:
  - sets `count_err` and `order_err`;
  - restarts the CRC and count with that pixel;
  - remains in CAPTURE.
- `count_err` is evaluated on EOF.
- `pixel_count` saturates at all-ones.

## Timing
- Reset: state IDLE; `busy`=0, `sig_valid`=0, `signature`=0, `pixel_count`=0, `order_err`=0, `count_err`=0.
- `busy` rises the cycle after `start` and falls the cycle `sig_valid` rises.
- Fold latency is 1 cycle: CRC and count are registered on the cycle of the accepted pixel.
- `sig_valid`, `signature` and `count_err` update on the cycle after the EOF pixel.
- Back-to-back accepted pixels are supported on every cycle; there is no stall and no backpressure.
- Reset asserted mid-capture returns to IDLE the next edge; a partial signature is never exposed.

## Configuration
- `VGA_SIG_COMPARE_EN` defined:
  - adds input `expected_sig` (32) and output `sig_match` (1);
  - `sig_match` = (`signature == expected_sig`), registered and qualified by `sig_valid`;
  - `sig_match` is 0 at reset and whenever `sig_valid`=0.
- Undefined: no port, no comparator; behaviour is otherwise identical.

## Structure
- Shared package `vga_pkg`:
  - CRC-32 polynomial, init and final-XOR constants;
  - FSM state enum (IDLE, SKIP, CAPTURE, DONE);
  - default 640x480 constants.
- One sub-module, `crc32_parallel`:
  - combinational next-CRC for a parametrised data width `DW`;
  - inputs `crc_in` and `data`, output `crc_out`;
  - also reused by future checkers.

## Test plan
- Reset mid-capture on a 4x2 frame at COLOR_W=8: pulse `reset_key`=0 after 3 pixels -> all outputs 0, `busy`=0 next cycle; a following `start` captures normally.
- `H_ACTIVE`=4, `V_ACTIVE`=2, all pixels 0x000000, `skip_frames`=0 -> `pixel_count`=8, `count_err`=0, `order_err`=0, `signature` equals the software CRC model, `sig_valid` one cycle after EOF.
- Same frame with `skip_frames`=2, frames 0–1 filled with 0xFFFFFF and frame 2 with 0x000000 -> signature equals the all-zero case.
- Drop pixel (2,1) from the frame -> `order_err`=1, `count_err`=1, `pixel_count`=7.
- `pixel_valid` toggling every other cycle (25 MHz) over a 640x480 frame -> `pixel_count`=307200, no errors; blanking coordinates ignored.
- With `VGA_SIG_COMPARE_EN`: `expected_sig` = model CRC -> `sig_match`=1; flip one LSB of `vga_b` at (1,0) -> `sig_match`=0, no raster errors. `start` issued mid-capture -> capture re-arms and `sig_valid` stays 0 until the next full frame.
